// File: rtl/defines_pw.sv
// -----------------------------------------------------------------------------
// defines_pw
// Shared definitions for the front-end capture packer:
//   state_t   - capture FSM states (also visible on the debug state port)
//   cmd_t     - 2-bit command field of the 18-bit capture word
//   pack_word - builds {cmd[17:16], delta[15:8], payload[7:0]}
// -----------------------------------------------------------------------------
package defines_pw;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_DATA = 2'b00,
        CMD_TIME = 2'b01,
        CMD_STAT = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_t;

    localparam logic [7:0] DELTA_MAX = 8'hFF;

    function automatic logic [17:0] pack_word(input cmd_t       cmd,
                                              input logic [7:0] delta,
                                              input logic [7:0] payload);
        return {cmd, delta, payload};
    endfunction

endpackage

// File: rtl/fe_packer_arb.sv
// -----------------------------------------------------------------------------
// fe_packer_arb
// Chooses the single word (if any) formed in a capture cycle and owns the
// line-status reference plus the one-deep pending STAT register.
//   fe_clk, reset_i  : clock, synchronous active-high reset
//   start_i          : capture entry; loads stat reference, clears pending
//   active_i         : capture cycle in which a word may be formed
//   data_valid_i/data_i : front-end byte strobe
//   stat_i           : front-end line status
//   delta_i          : current delta counter value
//   word_valid_o/word_o : combinational word formed this cycle
// Priority: DATA > STAT (fresh change or pending) > TIME.
// -----------------------------------------------------------------------------
module fe_packer_arb (
    input  logic        fe_clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        active_i,
    input  logic        data_valid_i,
    input  logic [7:0]  data_i,
    input  logic [7:0]  stat_i,
    input  logic [7:0]  delta_i,
    output logic        word_valid_o,
    output logic [17:0] word_o
);
    import defines_pw::*;

    logic [7:0] ref_q, ref_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_val_q, pend_val_d;

    logic       stat_change;
    logic       stat_cand_v;
    logic [7:0] stat_cand;

    always_comb begin
        // A fresh status change supersedes an older pending one: only the
        // newest line status is ever reported.
        stat_change  = (stat_i != ref_q);
        stat_cand_v  = stat_change || pend_q;
        stat_cand    = stat_change ? stat_i : pend_val_q;

        word_valid_o = 1'b0;
        word_o       = '0;
        ref_d        = ref_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;

        if (start_i) begin
            ref_d      = stat_i;
            pend_d     = 1'b0;
            pend_val_d = '0;
        end else if (active_i) begin
            ref_d = stat_i;
            if (data_valid_i) begin
                word_valid_o = 1'b1;
                word_o       = pack_word(CMD_DATA, delta_i, data_i);
                pend_d       = stat_cand_v;
                pend_val_d   = stat_cand;
            end else if (stat_cand_v) begin
                word_valid_o = 1'b1;
                word_o       = pack_word(CMD_STAT, delta_i, stat_cand);
                pend_d       = 1'b0;
            end else if (delta_i == DELTA_MAX) begin
                word_valid_o = 1'b1;
                word_o       = pack_word(CMD_TIME, DELTA_MAX, 8'h00);
            end
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            ref_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
        end else begin
            ref_q      <= ref_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

endmodule

// File: rtl/fe_capture_packer.sv
// -----------------------------------------------------------------------------
// fe_capture_packer
// Packs front-end bytes, line-status changes and idle timestamps into 18-bit
// words {cmd, delta, payload} for a capture FIFO.
// Ports:
//   fe_clk, reset_i          : clock, synchronous active-high reset
//   I_arm, I_trigger, I_abort: capture control (arm pulse, trigger level,
//                              abort pulse)
//   I_max_words              : stored-word limit, 0 = unlimited
//   I_data_valid, I_data     : front-end byte strobe
//   I_stat                   : front-end line status
//   I_fifo_full              : capture FIFO full
//   O_data, O_wr             : FIFO write port
//   O_capture_done           : high while in DONE
//   O_drop_sticky            : a word was dropped since the last accepted arm
//   O_dbg_state              : current FSM state (state_t encoding)
//
// Write handshake: O_wr is a registered one-cycle strobe qualifying O_data.
// A word formed in cycle t is written in cycle t+1 only if I_fifo_full was
// low in cycle t; otherwise it is dropped (sticky flag set, not counted).
// The FIFO full flag is therefore expected to leave room for one write.
// -----------------------------------------------------------------------------
module fe_capture_packer #(
    parameter int pCOUNT_WIDTH = 20
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_trigger,
    input  logic                    I_abort,
    input  logic [pCOUNT_WIDTH-1:0] I_max_words,
    input  logic                    I_data_valid,
    input  logic [7:0]              I_data,
    input  logic [7:0]              I_stat,
    input  logic                    I_fifo_full,
    output logic [17:0]             O_data,
    output logic                    O_wr,
    output logic                    O_capture_done,
    output logic                    O_drop_sticky,
    output logic [1:0]              O_dbg_state
);
    import defines_pw::*;

    localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                  state_q, state_d;
    logic [7:0]              delta_q, delta_d;
    logic [pCOUNT_WIDTH-1:0] count_q, count_d;
    logic                    wr_q, wr_d;
    logic [17:0]             data_q, data_d;
    logic                    sticky_q, sticky_d;

    logic        arm_accept;
    logic        start;
    logic        in_cap;
    logic        limit_hit;
    logic        active;
    logic        arb_valid;
    logic [17:0] arb_word;
    logic        store;
    logic        drop;

    assign in_cap    = (state_q == ST_CAPTURE);
    assign start     = (state_q == ST_ARMED) && I_trigger && !I_abort;
    // Limit reached: the cycle after the last stored word leaves CAPTURE and
    // forms no further words.
    assign limit_hit = in_cap && (I_max_words != '0) && (count_q == I_max_words);
    // The abort cycle forms no new word; a word already registered still goes out.
    assign active    = in_cap && !I_abort && !limit_hit;

    fe_packer_arb u_arb (
        .fe_clk       (fe_clk),
        .reset_i      (reset_i),
        .start_i      (start),
        .active_i     (active),
        .data_valid_i (I_data_valid),
        .data_i       (I_data),
        .stat_i       (I_stat),
        .delta_i      (delta_q),
        .word_valid_o (arb_valid),
        .word_o       (arb_word)
    );

    // FSM next state
    always_comb begin
        state_d    = state_q;
        arm_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!I_abort && I_arm) begin
                    state_d    = ST_ARMED;
                    arm_accept = 1'b1;
                end
            end
            ST_ARMED: begin
                if (I_abort) begin
                    state_d = ST_IDLE;
                end else if (I_trigger) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (I_abort || limit_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (I_arm) begin
                    state_d    = ST_ARMED;
                    arm_accept = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state
    always_comb begin
        store    = arb_valid && !I_fifo_full;
        drop     = arb_valid && I_fifo_full;

        delta_d  = delta_q;
        count_d  = count_q;
        wr_d     = store;
        data_d   = store ? arb_word : data_q;
        sticky_d = sticky_q;

        if (start) begin
            delta_d = '0;
            count_d = '0;
        end else if (active) begin
            // Any formed word restarts delta, including a dropped one.
            delta_d = arb_valid ? 8'd0 : delta_q + 8'd1;
            if (store) begin
                count_d = count_q + CNT_ONE;
            end
        end

        if (arm_accept) begin
            sticky_d = 1'b0;
        end else if (drop) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            delta_q  <= '0;
            count_q  <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            delta_q  <= delta_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
        end
    end

    assign O_wr           = wr_q;
    assign O_data         = data_q;
    assign O_capture_done = (state_q == ST_DONE);
    assign O_drop_sticky  = sticky_q;
    assign O_dbg_state    = state_q;

endmodule

// File: tb/tb_fe_capture_packer.sv
module tb_fe_capture_packer;
  import defines_pw::*;

  localparam int CW = 20;

  // ---------------- clock / reset / DUT ----------------
  logic          fe_clk;
  logic          reset_i;
  logic          I_arm, I_trigger, I_abort;
  logic [CW-1:0] I_max_words;
  logic          I_data_valid;
  logic [7:0]    I_data, I_stat;
  logic          I_fifo_full;
  logic [17:0]   O_data;
  logic          O_wr, O_capture_done, O_drop_sticky;
  logic [1:0]    O_dbg_state;

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  fe_capture_packer #(.pCOUNT_WIDTH(CW)) dut (
    .fe_clk         (fe_clk),
    .reset_i        (reset_i),
    .I_arm          (I_arm),
    .I_trigger      (I_trigger),
    .I_abort        (I_abort),
    .I_max_words    (I_max_words),
    .I_data_valid   (I_data_valid),
    .I_data         (I_data),
    .I_stat         (I_stat),
    .I_fifo_full    (I_fifo_full),
    .O_data         (O_data),
    .O_wr           (O_wr),
    .O_capture_done (O_capture_done),
    .O_drop_sticky  (O_drop_sticky),
    .O_dbg_state    (O_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Delta is the number of capture cycles since capture start or since the
  // last formed word; the pending status is a queue holding at most the
  // newest unreported value.
  int          cyc = 0;
  state_t      m_state = ST_IDLE;
  bit          m_sticky = 1'b0;
  int          m_base = 0;
  int          m_stored = 0;
  logic [7:0]  m_ref = 8'h00;
  logic [7:0]  m_pend[$];
  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          check_en = 1'b0;

  int          mc, mdelta;
  logic [7:0]  md8;
  logic [17:0] mw;
  bit          mhave, mchg;

  always @(posedge fe_clk) begin
    mc = cyc;
    cyc++;
    if (reset_i) begin
      m_state  = ST_IDLE;
      m_sticky = 1'b0;
      m_pend.delete();
    end else begin
      case (m_state)
        ST_IDLE:
          if (!I_abort && I_arm) begin
            m_state = ST_ARMED; m_sticky = 1'b0;
          end
        ST_ARMED:
          if (I_abort) m_state = ST_IDLE;
          else if (I_trigger) begin
            m_state = ST_CAPTURE; m_base = mc + 1; m_ref = I_stat;
            m_pend.delete(); m_stored = 0;
          end
        ST_CAPTURE: begin
          if (I_abort || (I_max_words != 0 && m_stored == int'(I_max_words))) begin
            m_state = ST_DONE;
          end else begin
            mdelta = mc - m_base;
            md8    = mdelta[7:0];
            mhave  = 1'b0;
            mchg   = (I_stat != m_ref);
            if (I_data_valid) begin
              mhave = 1'b1; mw = {2'b00, md8, I_data};
              if (mchg) begin m_pend.delete(); m_pend.push_back(I_stat); end
            end else if (mchg) begin
              mhave = 1'b1; mw = {2'b10, md8, I_stat}; m_pend.delete();
            end else if (m_pend.size() > 0) begin
              mhave = 1'b1; mw = {2'b10, md8, m_pend[0]}; m_pend.delete();
            end else if (mdelta == 255) begin
              mhave = 1'b1; mw = {2'b01, 8'hFF, 8'h00};
            end
            m_ref = I_stat;
            if (mhave) begin
              m_base = mc + 1;
              if (I_fifo_full) m_sticky = 1'b1;
              else begin
                exp_q.push_back(mw); exp_cyc_q.push_back(mc + 1); m_stored++;
              end
            end
          end
        end
        ST_DONE:
          if (I_arm) begin m_state = ST_ARMED; m_sticky = 1'b0; end
        default: m_state = ST_IDLE;
      endcase
    end
  end

  // ---------------- compare process + write monitor ----------------
  logic [17:0] obs_w[$];
  int          obs_c[$];
  bit          exp_wr;

  always @(negedge fe_clk) begin
    if (O_wr === 1'b1) begin
      obs_w.push_back(O_data); obs_c.push_back(cyc);
    end
    if (check_en) begin
      exp_wr = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      check("o_wr", O_wr, exp_wr);
      if (exp_wr) begin
        check("o_data", O_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      check("capture_done", O_capture_done, m_state == ST_DONE);
      check("drop_sticky", O_drop_sticky, m_sticky);
      check("state", O_dbg_state, m_state);
    end
  end

  // ---------------- driver tasks ----------------
  int cap_start = 0;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic pulse_arm();
    I_arm = 1'b1; tick(); I_arm = 1'b0;
  endtask

  task automatic pulse_abort();
    I_abort = 1'b1; tick(); I_abort = 1'b0;
  endtask

  task automatic do_trigger();
    I_trigger = 1'b1; tick(); I_trigger = 1'b0;
    cap_start = cyc;
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_c.delete();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  int p_dv, p_stat, p_full, p_abort;

  initial begin
    reset_i = 1'b1; I_arm = 0; I_trigger = 0; I_abort = 0; I_max_words = '0;
    I_data_valid = 0; I_data = 8'h00; I_stat = 8'h01; I_fifo_full = 0;
    ticks(3);
    reset_i = 1'b0;
    check_en = 1'b1;
    check("reset_wr", O_wr, 1'b0);
    check("reset_data", O_data, 18'h0);
    check("reset_done", O_capture_done, 1'b0);
    check("reset_sticky", O_drop_sticky, 1'b0);
    check("reset_state", O_dbg_state, ST_IDLE);

    // DATA byte at delta 3
    pulse_arm(); do_trigger(); clear_obs();
    ticks(3);
    I_data_valid = 1; I_data = 8'hA5; tick(); I_data_valid = 0;
    ticks(2);
    check("d33_count", obs_w.size(), 1);
    if (obs_w.size() >= 1) begin
      check("d33_word", obs_w[0], 18'h003A5);
      check("d33_cycle", obs_c[0] - cap_start, 4);
    end
    pulse_abort();
    check("d33_done", O_capture_done, 1'b1);

    // DATA + STAT collision: DATA first, STAT next cycle
    pulse_arm(); do_trigger(); clear_obs();
    ticks(2);
    I_data_valid = 1; I_data = 8'h5A; I_stat = 8'h02; tick(); I_data_valid = 0;
    ticks(3);
    check("col_count", obs_w.size(), 2);
    if (obs_w.size() >= 2) begin
      check("col_data", obs_w[0], 18'h0025A);
      check("col_stat", obs_w[1], 18'h20002);
      check("col_adjacent", obs_c[1] - obs_c[0], 1);
    end
    pulse_abort();

    // 300 idle capture cycles: one TIME word
    pulse_arm(); do_trigger(); clear_obs();
    ticks(300);
    check("time_count", obs_w.size(), 1);
    if (obs_w.size() >= 1) begin
      check("time_word", obs_w[0], 18'h1FF00);
      check("time_cycle", obs_c[0] - cap_start, 256);
    end
    pulse_abort();

    // word limit 4 with 6 bytes
    I_max_words = 4;
    pulse_arm(); do_trigger(); clear_obs();
    for (int i = 0; i < 6; i++) begin
      I_data_valid = 1; I_data = 8'h10 + 8'(i); tick();
    end
    I_data_valid = 0;
    ticks(3);
    check("lim_count", obs_w.size(), 4);
    if (obs_w.size() >= 4) begin
      check("lim_first", obs_w[0], 18'h00010);
      check("lim_last", obs_w[3], 18'h00013);
    end
    check("lim_done", O_capture_done, 1'b1);
    I_max_words = '0;

    // FIFO full during a byte: dropped, sticky until next arm
    pulse_arm(); do_trigger(); clear_obs();
    ticks(2);
    I_data_valid = 1; I_data = 8'h77; I_fifo_full = 1; tick();
    I_data_valid = 0; I_fifo_full = 0;
    ticks(3);
    check("full_count", obs_w.size(), 0);
    check("full_sticky", O_drop_sticky, 1'b1);
    ticks(20);
    check("full_sticky_hold", O_drop_sticky, 1'b1);
    pulse_abort();
    check("full_sticky_done", O_drop_sticky, 1'b1);
    pulse_arm();
    check("full_sticky_arm", O_drop_sticky, 1'b0);

    // reset mid-capture with STAT pending
    do_trigger();
    tick();
    I_data_valid = 1; I_fifo_full = 1; tick(); I_data_valid = 0; I_fifo_full = 0;
    tick();
    I_data_valid = 1; I_data = 8'h33; I_stat = 8'h05; tick(); I_data_valid = 0;
    reset_i = 1'b1; tick();
    check("rst_wr", O_wr, 1'b0);
    check("rst_data", O_data, 18'h0);
    check("rst_done", O_capture_done, 1'b0);
    check("rst_sticky", O_drop_sticky, 1'b0);
    check("rst_state", O_dbg_state, ST_IDLE);
    tick();
    reset_i = 1'b0;

    // randomized segments against the model
    for (int seg = 0; seg < 24; seg++) begin
      case ($urandom_range(0, 3))
        0: begin p_dv = 0;  p_stat = 0;  p_full = 0;  p_abort = 0; end
        1: begin p_dv = 5;  p_stat = 3;  p_full = 10; p_abort = 1; end
        2: begin p_dv = 40; p_stat = 20; p_full = 10; p_abort = 1; end
        default: begin p_dv = 90; p_stat = 30; p_full = 50; p_abort = 2; end
      endcase
      for (int i = 0; i < 400; i++) begin
        I_arm = ($urandom_range(0, 29) == 0);
        if (I_arm) I_max_words = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 20));
        I_trigger    = ($urandom_range(0, 3) == 0);
        I_abort      = ($urandom_range(0, 199) < p_abort);
        I_data_valid = ($urandom_range(0, 99) < p_dv);
        I_data       = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 99) < p_stat) I_stat = 8'($urandom_range(0, 255));
        I_fifo_full  = ($urandom_range(0, 99) < p_full);
        reset_i      = ($urandom_range(0, 1999) == 0);
        tick();
      end
    end

    I_arm = 0; I_trigger = 0; I_abort = 0; I_data_valid = 0; I_fifo_full = 0; reset_i = 0;
    pulse_abort();
    ticks(4);
    check("exp_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
